// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-ramp feeder.
//   - default widths for duty/target, rate counter and step size
//   - ramp FSM state encoding
//   - sat_step(): one clamped slew step toward a target, computed in a
//     width wide enough that neither the add nor the subtract can wrap
package pwm_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int RATE_W_DEF = 8;
    localparam int STEP_W_DEF = 4;

    // Working width for step arithmetic; callers zero-extend duty/step/target
    // into this width, so any DUTY_W up to SAT_W-1 is wrap-free.
    localparam int SAT_W = 17;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // up=1 : min(duty + step, target)
    // up=0 : max(duty - step, target), where a step larger than duty would
    //        go below zero; since target >= 0 the clamp lands on target.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] duty,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] target,
        input logic             up
    );
        logic [SAT_W-1:0] res;
        if (up) begin
            res = duty + step;
            if (res > target) res = target;
        end else if (step >= duty) begin
            res = target;
        end else begin
            res = duty - step;
            if (res < target) res = target;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_rate_div.sv
// Step-rate divider for the duty ramp.
// Counts qualified period_end pulses; when the count equals rate_q a
// one-cycle step_tick is produced (combinationally, in the same cycle as
// the period_end) and the count restarts from 0.
//   clk        system clock
//   rst        synchronous active-high reset
//   clear      restart the count from 0 (takes priority over period_end)
//   period_end qualified period boundary pulse (caller gates with ena/state)
//   rate_q     extra period_end pulses between steps
//   step_tick  take a step this cycle
module pwm_rate_div
    import pwm_pkg::*;
#(
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              period_end,
    input  logic [RATE_W-1:0] rate_q,
    output logic              step_tick
);

    logic [RATE_W-1:0] rate_cnt_q;
    logic [RATE_W-1:0] rate_cnt_d;
    logic              terminal;

    always_comb begin
        terminal   = (rate_cnt_q == rate_q);
        step_tick  = 1'b0;
        rate_cnt_d = rate_cnt_q;
        if (clear) begin
            rate_cnt_d = '0;
        end else if (period_end) begin
            if (terminal) begin
                step_tick  = 1'b1;
                rate_cnt_d = '0;
            end else begin
                rate_cnt_d = rate_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rate_cnt_q <= '0;
        else     rate_cnt_q <= rate_cnt_d;
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew controller feeding the PWM comparator.
// A load strobe captures a target, step size and rate; the live duty then
// moves toward the target by step_q every (rate_q+1) PWM periods. duty_out
// only changes on the cycle after a period_end, so the PWM (which latches at
// its next wrap) never sees a mid-period update.
//   clk         system clock
//   rst         synchronous active-high reset
//   ena         enable; low freezes all state and masks done
//   load        capture target_in / step_in / rate_in
//   target_in   requested duty
//   step_in     duty increment per step (0 behaves as 1)
//   rate_in     extra period_end pulses between steps
//   period_end  PWM counter wrap pulse
//   duty_out    live duty
//   busy        registered, high while not IDLE
//   done        one-cycle pulse when duty_out reaches the target
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | duty_out equals target, period_end ignored
// RAMP_UP   | duty_out below target, stepping upward
// RAMP_DOWN | duty_out above target, stepping downward
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              load,
    input  logic [DUTY_W-1:0] target_in,
    input  logic [STEP_W-1:0] step_in,
    input  logic [RATE_W-1:0] rate_in,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    ramp_state_t       state_q,  state_d;
    logic [DUTY_W-1:0] duty_q,   duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [RATE_W-1:0] rate_q,   rate_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic              ramping;
    logic              load_en;
    logic              pe_qual;
    logic              step_tick;
    logic [SAT_W-1:0]  stepped_w;
    logic [DUTY_W-1:0] stepped;

    assign ramping = (state_q != IDLE);
    assign load_en = ena && load;
    // A load on the same edge as period_end wins and swallows that pulse.
    assign pe_qual = ena && !load && ramping && period_end;

    pwm_rate_div #(
        .RATE_W (RATE_W)
    ) u_rate_div (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_en),
        .period_end (pe_qual),
        .rate_q     (rate_q),
        .step_tick  (step_tick)
    );

    assign stepped_w = sat_step(SAT_W'(duty_q), SAT_W'(step_q),
                                SAT_W'(target_q), state_q == RAMP_UP);
    assign stepped   = DUTY_W'(stepped_w);

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        rate_d   = rate_q;
        done_d   = 1'b0;

        if (load_en) begin
            target_d = target_in;
            step_d   = (step_in == '0) ? STEP_W'(1) : step_in;
            rate_d   = rate_in;
            if (target_in > duty_q) begin
                state_d = RAMP_UP;
            end else if (target_in < duty_q) begin
                state_d = RAMP_DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (ena && ramping && step_tick) begin
            duty_d = stepped;
            if (stepped == target_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= STEP_W'(1);
            rate_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            rate_q   <= rate_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    // Masked so a pulse pending when ena drops is not seen downstream.
    assign done     = done_q && ena;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       load = 1'b0;
    logic [7:0] target_in = '0;
    logic [3:0] step_in = '0;
    logic [7:0] rate_in = '0;
    logic       period_end = 1'b0;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    pwm_duty_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
        .target_in  (target_in),
        .step_in    (step_in),
        .rate_in    (rate_in),
        .period_end (period_end),
        .duty_out   (duty_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int d, input logic b, input logic dn);
        chk({tag, ".duty"}, 32'(duty_out), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic do_load(input int t, input int s, input int r);
        target_in = 8'(t);
        step_in   = 4'(s);
        rate_in   = 8'(r);
        load      = 1'b1;
        step();
        load      = 1'b0;
        target_in = 8'hAA;
        step_in   = 4'h3;
        rate_in   = 8'h07;
    endtask

    task automatic pe();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
    endtask

    initial begin
        // Reset, including a load held under reset
        rst = 1'b1;
        idle(2);
        chk3("rst", 0, 1'b0, 1'b0);
        target_in = 8'd99; step_in = 4'd9; load = 1'b1;
        step();
        load = 1'b0;
        chk3("rst_load", 0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        pe();
        chk3("idle_pe", 0, 1'b0, 1'b0);

        // Up ramp 0 -> 20, step 5, every period
        do_load(20, 5, 0);
        chk3("up_load", 0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            pe();
            chk3($sformatf("up%0d", k), 5 * k, (k != 4), (k == 4));
            idle(15);
        end
        chk("up_done_once", 32'(done), 32'd0);
        pe();
        chk3("up_idle_pe", 20, 1'b0, 1'b0);

        // Climb to 250: 20 + 15*15 = 245, then clamp to 250
        do_load(250, 15, 0);
        for (int k = 0; k < 15; k++) pe();
        chk3("to245", 245, 1'b1, 1'b0);
        pe();
        chk3("to250", 250, 1'b0, 1'b1);

        // Saturation at the top with rate 2: no wrap past 255
        do_load(255, 15, 2);
        pe();
        chk3("sat_pe1", 250, 1'b1, 1'b0);
        pe();
        chk3("sat_pe2", 250, 1'b1, 1'b0);
        pe();
        chk3("sat_pe3", 255, 1'b0, 1'b1);

        // Down 255 -> 7 with step 15: 16 steps reach 15, 17th clamps at 7
        do_load(7, 15, 0);
        for (int k = 0; k < 16; k++) pe();
        chk3("dn15", 15, 1'b1, 1'b0);
        pe();
        chk3("dn7", 7, 1'b0, 1'b1);

        // 7 -> 0 with step 15: one step, no underflow
        do_load(0, 15, 0);
        chk("dn0_busy", 32'(busy), 32'd1);
        pe();
        chk3("dn0", 0, 1'b0, 1'b1);

        // step_in = 0 acts as 1
        do_load(2, 0, 0);
        pe();
        chk3("step0_a", 1, 1'b1, 1'b0);
        pe();
        chk3("step0_b", 2, 1'b0, 1'b1);

        // Reversal: ramp 2 -> 100 by 10 until 42, then retarget 12 by 10
        do_load(100, 10, 0);
        for (int k = 0; k < 4; k++) pe();
        chk3("rev_at42", 42, 1'b1, 1'b0);
        do_load(12, 10, 0);
        chk3("rev_load", 42, 1'b1, 1'b0);
        pe();
        chk3("rev32", 32, 1'b1, 1'b0);
        pe();
        chk3("rev22", 22, 1'b1, 1'b0);
        pe();
        chk3("rev12", 12, 1'b0, 1'b1);
        step();
        chk("rev_done_once", 32'(done), 32'd0);

        // Load and period_end together: no step, counter restarts at 0
        period_end = 1'b1;
        do_load(50, 5, 1);
        period_end = 1'b0;
        chk3("coll_load", 12, 1'b1, 1'b0);
        pe();
        chk3("coll_pe1", 12, 1'b1, 1'b0);
        pe();
        chk3("coll_pe2", 17, 1'b1, 1'b0);

        // Load target equal to current duty
        do_load(17, 3, 0);
        chk3("eq_load", 17, 1'b0, 1'b1);
        step();
        chk3("eq_after", 17, 1'b0, 1'b0);

        // Enable freeze mid-ramp: 17 -> 40, step 5, rate 1
        do_load(40, 5, 1);
        pe();
        pe();
        chk3("frz_pre", 22, 1'b1, 1'b0);
        pe();                      // counter now 1, next pe steps
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pe();
            idle(2);
        end
        do_load(0, 1, 0);          // ignored while disabled
        chk3("frz_hold", 22, 1'b1, 1'b0);
        ena = 1'b1;
        step();
        chk3("frz_resume0", 22, 1'b1, 1'b0);
        pe();
        chk3("frz_resume1", 27, 1'b1, 1'b0);
        pe();
        pe();
        chk3("frz_resume2", 32, 1'b1, 1'b0);

        // Reset in the middle of a ramp with a simultaneous load
        rst = 1'b1;
        do_load(200, 5, 0);
        rst = 1'b0;
        chk3("rst_mid", 0, 1'b0, 1'b0);
        pe();
        chk3("rst_mid_pe", 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
